// File: rtl/tff_pkg.sv
// Shared types for the T flip-flop bank: operating mode and count direction.
package tff_pkg;

  typedef enum logic {
    TFF_INDEP = 1'b0,
    TFF_COUNT = 1'b1
  } tff_mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// Single T flip-flop channel with asynchronous reset to a per-bit value and
// synchronous parallel load that takes priority over the toggle request.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic load,
  input  logic d,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next state: load wins over toggle, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  // State register, cleared to the channel's reset value asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : tff_cell

// File: rtl/tff_bank.sv
// WIDTH-channel T flip-flop bank. INDEP mode toggles each bit on its own mask
// bit; COUNT mode chains the bits into a masked binary up/down counter with a
// registered terminal-count pulse on wrap.
// Optional build macro: TFF_BANK_SAT_EN -- COUNT mode saturates instead of
// wrapping; tc then flags every suppressed step.
module tff_bank
  import tff_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  tff_mode_e        mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] carry_c;
  logic [WIDTH-1:0] toggle_c;
  logic             end_val_c;
  logic             wrap_c;
  logic             tc_d;
  logic             tc_q;

  // Carry (up) / borrow (down) chain: bit i may step only when every lower
  // bit sits at the rollover value. Masked bits still feed the chain.
  always_comb begin
    carry_c    = '0;
    carry_c[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      if (dir == DIR_UP) begin
        carry_c[i] = carry_c[i-1] & q[i-1];
      end else begin
        carry_c[i] = carry_c[i-1] & ~q[i-1];
      end
    end
  end

  // Wrap detect: a full-mask count step from the terminal value.
  always_comb begin
    end_val_c = (dir == DIR_UP) ? (&q) : ~(|q);
    wrap_c    = en & (mode == TFF_COUNT) & (&t) & end_val_c;
  end

  // Per-bit toggle requests handed to the cells; load overrides inside the cell.
  always_comb begin
    toggle_c = '0;
    if (en) begin
      if (mode == TFF_INDEP) begin
        toggle_c = t;
      end else begin
        toggle_c = t & carry_c;
      end
`ifdef TFF_BANK_SAT_EN
      if (wrap_c) begin
        toggle_c = '0;
      end
`endif
    end
  end

  // Terminal count is raised for the cycle after a wrap (or suppressed wrap).
  always_comb begin
    tc_d = 1'b0;
    if (!load) begin
      tc_d = wrap_c;
    end
  end

  // Terminal-count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign tc = tc_q;

  // One T flip-flop per channel.
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RESET_VAL[g]),
      .load    (load),
      .d       (load_val[g]),
      .t       (toggle_c[g]),
      .q       (q[g])
    );
  end

endmodule : tff_bank

// File: tb/tb_tff_bank.sv
// Self-checking bench for tff_bank (WIDTH=4, RESET_VAL=4'hA): directed cases
// followed by randomized stimulus against a behavioural reference model.
module tb_tff_bank;
  import tff_pkg::*;

  localparam int unsigned W    = 4;
  localparam logic [W-1:0] RV  = 4'hA;
  localparam logic [W-1:0] ALL = '1;

  logic         clk;
  logic         reset;
  logic         en;
  tff_mode_e    mode;
  logic         dir;
  logic [W-1:0] t;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;

  logic [W-1:0] exp_q;
  logic         exp_tc;
  int           n_cmp;
  int           n_err;

  tff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .t        (t),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running wanted finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model of one clock edge, from the behavioural rules.
  task automatic model_edge();
    int unsigned  cur;
    int unsigned  mx;
    logic [W-1:0] nq;
    logic [W-1:0] low;
    cur = int'(exp_q);
    mx  = (1 << W) - 1;
    if (load) begin
      exp_q  = load_val;
      exp_tc = 1'b0;
    end else if (!en) begin
      exp_tc = 1'b0;
    end else if (mode == TFF_INDEP) begin
      exp_q  = exp_q ^ t;
      exp_tc = 1'b0;
    end else if (t == ALL) begin
      exp_tc = 1'b0;
      if (dir == DIR_UP) begin
        if (cur == mx) begin
          exp_tc = 1'b1;
`ifndef TFF_BANK_SAT_EN
          exp_q  = '0;
`endif
        end else begin
          exp_q = W'(cur + 1);
        end
      end else begin
        if (cur == 0) begin
          exp_tc = 1'b1;
`ifndef TFF_BANK_SAT_EN
          exp_q  = ALL;
`endif
        end else begin
          exp_q = W'(cur - 1);
        end
      end
    end else begin
      nq = exp_q;
      for (int i = 0; i < int'(W); i++) begin
        low = W'((1 << i) - 1);
        if (t[i] && ((exp_q & low) == ((dir == DIR_UP) ? low : W'(0)))) begin
          nq[i] = ~exp_q[i];
        end
      end
      exp_q  = nq;
      exp_tc = 1'b0;
    end
  endtask

  // Advance one edge, update the model, then compare just after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_tc"}, 32'(tc), 32'(exp_tc));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    step("load");
    load     = 1'b0;
  endtask

  // Async reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    exp_q  = RV;
    exp_tc = 1'b0;
    check({tag, "_q"}, 32'(q), 32'(RV));
    check({tag, "_tc"}, 32'(tc), 32'(0));
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    en       = 1'b0;
    mode     = TFF_INDEP;
    dir      = DIR_UP;
    t        = '0;
    load     = 1'b0;
    load_val = '0;
    exp_q    = RV;
    exp_tc   = 1'b0;

    // Reset asserted between edges takes effect immediately.
    #2;
    reset = 1'b1;
    #1;
    check("rst_q", 32'(q), 32'(RV));
    check("rst_tc", 32'(tc), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("hold");
    check("hold_lit", 32'(q), 32'(4'hA));

    // INDEP toggling with a mask.
    mode = TFF_INDEP;
    en   = 1'b1;
    t    = 4'b0101;
    step("indep1");
    check("indep1_lit", 32'(q), 32'(4'hF));
    step("indep2");
    check("indep2_lit", 32'(q), 32'(4'hA));

    // COUNT up across the wrap.
    mode = TFF_COUNT;
    dir  = DIR_UP;
    t    = ALL;
    do_load(4'hE);
    step("up1");
    check("up1_lit", 32'(q), 32'(4'hF));
    step("up2");
`ifdef TFF_BANK_SAT_EN
    check("up2_lit", 32'(q), 32'(4'hF));
`else
    check("up2_lit", 32'(q), 32'(4'h0));
`endif
    check("up2_tc", 32'(tc), 32'(1));
    step("up3");
`ifdef TFF_BANK_SAT_EN
    check("up3_tc", 32'(tc), 32'(1));
`else
    check("up3_lit", 32'(q), 32'(4'h1));
    check("up3_tc", 32'(tc), 32'(0));
`endif

    // COUNT down across the borrow.
    do_load(4'h1);
    dir = DIR_DOWN;
    step("dn1");
    check("dn1_lit", 32'(q), 32'(4'h0));
    step("dn2");
    check("dn2_tc", 32'(tc), 32'(1));
`ifndef TFF_BANK_SAT_EN
    check("dn2_lit", 32'(q), 32'(4'hF));
    step("dn3");
    check("dn3_lit", 32'(q), 32'(4'hE));
    check("dn3_tc", 32'(tc), 32'(0));
`endif

    // Load beats toggle; reset beats everything, asynchronously.
    dir = DIR_UP;
    do_load(4'h5);
    check("prio_lit", 32'(q), 32'(4'h5));
    check("prio_tc", 32'(tc), 32'(0));
    step("cnt1");
    step("cnt2");
    pulse_reset("midrst");

    // Masked count: bit 2 held but still feeds the carry chain.
    mode = TFF_COUNT;
    dir  = DIR_UP;
    en   = 1'b1;
    do_load(4'h3);
    t = 4'b1011;
    step("mask1");
    check("mask1_lit", 32'(q), 32'(4'h0));
    t = ALL;
    do_load(4'h7);
    t = 4'b1011;
    step("mask2");
    check("mask2_lit", 32'(q), 32'(4'hC));

    // Randomized stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      en       = ($urandom_range(0, 9) != 0);
      mode     = tff_mode_e'(1'($urandom));
      dir      = 1'($urandom);
      t        = ($urandom_range(0, 2) != 0) ? ALL : W'($urandom);
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom);
      step("rnd");
      if ($urandom_range(0, 49) == 0) pulse_reset("rndrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_tff_bank
